expand_squ_fetch_ctrl: RTL and testbench

- Consumer end of the squeeze RAM request interface. Waits for the squeeze RAM controller to flag a full buffer, then issues one squ_data_req_o pulse per stored word.
- Replays the buffer once per expand kernel. Aligns the RAM read latency and delivers 3x3/1x1 squeeze words, tagged with word and kernel indices, to the expand MAC pipeline through a small credit-based output FIFO with backpressure.

---
 rtl/expand_squ_fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_expand_squ_fetch_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/expand_squ_fetch_ctrl.sv
// expand_squ_fetch_ctrl: replays the full squeeze buffer once per expand kernel,
// aligns the RAM read latency and hands tagged words to a credit-guarded FWFT FIFO.
module expand_squ_fetch_ctrl #(
  parameter int RD_LAT    = 2,
  parameter int BUF_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        exp_1x1_en_i,
  input  logic [8:0]  tot_squ_addr_limit_i,
  input  logic [9:0]  squ_kernals_i,
  input  logic        squ_data_ready_i,
  output logic        squ_data_req_o,
  input  logic [95:0] squ_3x3_data_i,
  input  logic [95:0] squ_1x1_data_i,
  output logic        exp_valid_o,
  input  logic        exp_ready_i,
  output logic [95:0] exp_3x3_data_o,
  output logic [95:0] exp_1x1_data_o,
  output logic [8:0]  exp_word_idx_o,
  output logic [9:0]  exp_kernal_idx_o,
  output logic        exp_last_word_o,
  output logic        exp_last_kernal_o,
  output logic        pass_done_o
);
  localparam int TW = 21;
  localparam int EW = TW + 192;
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int NW = $clog2(BUF_DEPTH + 1);
  localparam int CW = $clog2(BUF_DEPTH + RD_LAT + 2) + 1;

  typedef enum logic [2:0] {IDLE, WAIT_RDY, FETCH, WAIT_LOW, DRAIN} state_t;
  state_t r_state, w_next;

  logic [8:0]    r_limit, r_word;
  logic [9:0]    r_kernals, r_kern;
  logic          r_en_1x1, r_done;
  logic [RD_LAT:0] r_pv;
  logic [TW-1:0] r_pt [RD_LAT+1];
  logic [EW-1:0] r_mem [BUF_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [NW-1:0] r_cnt;
  logic [CW-1:0] w_used;
  logic [EW-1:0] w_head;
  logic          w_fire, w_push, w_pop, w_valid, w_done, w_last_word, w_last_kern;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_last_word = r_word == r_limit;
  assign w_last_kern = w_last_word && (r_kern == r_kernals);
  assign w_valid     = r_cnt != '0;
  assign w_pop       = w_valid && exp_ready_i;
  assign w_push      = r_pv[RD_LAT];
  // A pop on this edge frees its slot for the request being decided now
  assign w_used      = CW'(r_cnt) + CW'($countones(r_pv)) - CW'(w_pop);
  assign w_fire      = (r_state == FETCH) && squ_data_ready_i && (w_used < CW'(BUF_DEPTH));
  assign w_head      = r_mem[r_rp];

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      WAIT_RDY: w_next = squ_data_ready_i ? FETCH : WAIT_RDY;
      FETCH:    w_next = (w_fire && w_last_kern) ? WAIT_LOW : FETCH;
      WAIT_LOW: w_next = squ_data_ready_i ? WAIT_LOW : DRAIN;
      DRAIN: begin
        w_done = (r_pv == '0) && !w_valid;
        w_next = w_done ? WAIT_RDY : DRAIN;
      end
      default:  w_next = IDLE;
    endcase
    if (start_i) begin
      w_next = WAIT_RDY;
      w_done = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_limit   <= '0;
      r_kernals <= '0;
      r_en_1x1  <= 1'b0;
      r_word    <= '0;
      r_kern    <= '0;
      r_pv      <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
    end else if (start_i) begin
      r_limit   <= tot_squ_addr_limit_i;
      r_kernals <= squ_kernals_i;
      r_en_1x1  <= exp_1x1_en_i;
      r_word    <= '0;
      r_kern    <= '0;
      r_pv      <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_pv   <= {r_pv[RD_LAT-1:0], w_fire};
      r_done <= w_done;
      if (w_fire) begin
        r_word <= w_last_word ? '0 : r_word + 1'b1;
        r_kern <= w_last_kern ? '0 : (w_last_word ? r_kern + 1'b1 : r_kern);
      end
      if (w_push) r_wp <= f_inc(r_wp);
      if (w_pop)  r_rp <= f_inc(r_rp);
      r_cnt <= r_cnt + NW'(w_push) - NW'(w_pop);
    end
  end

  // Tags ride alongside the request so they meet the data when it returns
  always_ff @(posedge clk_i) begin
    r_pt[0] <= {w_last_kern, w_last_word, r_kern, r_word};
    for (int i = 1; i <= RD_LAT; i++) r_pt[i] <= r_pt[i-1];
    if (w_push) r_mem[r_wp] <= {r_pt[RD_LAT], squ_1x1_data_i, squ_3x3_data_i};
  end

  assign squ_data_req_o    = r_pv[0];
  assign pass_done_o       = r_done;
  assign exp_valid_o       = w_valid;
  assign exp_3x3_data_o    = w_valid ? w_head[95:0] : '0;
  assign exp_1x1_data_o    = (w_valid && r_en_1x1) ? w_head[191:96] : '0;
  assign exp_word_idx_o    = w_valid ? w_head[200:192] : '0;
  assign exp_kernal_idx_o  = w_valid ? w_head[210:201] : '0;
  assign exp_last_word_o   = w_valid && w_head[211];
  assign exp_last_kernal_o = w_valid && w_head[212];
endmodule

// File: tb/tb_expand_squ_fetch_ctrl.sv
// tb_expand_squ_fetch_ctrl: scenario tasks against a queue-based model of the
// request stream, RAM latency and expected output word order.
module tb_expand_squ_fetch_ctrl;
  localparam int RD_LAT    = 2;
  localparam int BUF_DEPTH = 4;

  logic        clk_i = 0, rst_n_i = 1, start_i = 0, exp_1x1_en_i = 0;
  logic [8:0]  cfg_limit = 0;
  logic [9:0]  cfg_kern = 0;
  logic        squ_data_ready_i = 0, exp_ready_i = 1;
  logic [95:0] squ_3x3_data_i = 0, squ_1x1_data_i = 0;
  logic        squ_data_req_o, exp_valid_o, exp_last_word_o, exp_last_kernal_o, pass_done_o;
  logic [95:0] exp_3x3_data_o, exp_1x1_data_o;
  logic [8:0]  exp_word_idx_o;
  logic [9:0]  exp_kernal_idx_o;

  expand_squ_fetch_ctrl #(.RD_LAT(RD_LAT), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .exp_1x1_en_i(exp_1x1_en_i),
    .tot_squ_addr_limit_i(cfg_limit), .squ_kernals_i(cfg_kern),
    .squ_data_ready_i(squ_data_ready_i), .squ_data_req_o(squ_data_req_o),
    .squ_3x3_data_i(squ_3x3_data_i), .squ_1x1_data_i(squ_1x1_data_i),
    .exp_valid_o(exp_valid_o), .exp_ready_i(exp_ready_i),
    .exp_3x3_data_o(exp_3x3_data_o), .exp_1x1_data_o(exp_1x1_data_o),
    .exp_word_idx_o(exp_word_idx_o), .exp_kernal_idx_o(exp_kernal_idx_o),
    .exp_last_word_o(exp_last_word_o), .exp_last_kernal_o(exp_last_kernal_o),
    .pass_done_o(pass_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [95:0] d3, d1;
    logic [8:0]  w;
    logic [9:0]  k;
    logic        lw, lk;
  } exp_t;
  typedef struct {
    int          due;
    logic [95:0] d3, d1;
  } pend_t;

  exp_t  exp_q[$];
  pend_t pend_q[$];
  int    checks = 0, errors = 0, cyc = 0;
  int    m_limit = 0, m_kern = 0;
  bit    m_en = 1, ones_1x1 = 0;
  int    n_req = 0, n_pop = 0, n_done = 0, first_req = -1, last_req = -1, first_val = -1;
  logic  obs_lw = 0, obs_lk = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Producer + consumer model: words are numbered in request order within a pass
  exp_t        e;
  pend_t       p;
  logic [95:0] x1;
  always @(negedge clk_i) begin
    if (squ_data_req_o) begin
      e.d3 = {$urandom, $urandom, $urandom};
      e.d1 = ones_1x1 ? '1 : {$urandom, $urandom, $urandom};
      e.w  = 9'(n_req % (m_limit + 1));
      e.k  = 10'(n_req / (m_limit + 1));
      e.lw = (n_req % (m_limit + 1)) == m_limit;
      e.lk = n_req == (m_limit + 1) * (m_kern + 1) - 1;
      exp_q.push_back(e);
      pend_q.push_back('{cyc + RD_LAT, e.d3, e.d1});
      n_req++;
      if (first_req < 0) first_req = cyc;
      last_req = cyc;
      checks++;
      if (n_req - n_pop > BUF_DEPTH || n_req > (m_limit + 1) * (m_kern + 1)) begin
        errors++;
        $display("FAIL credit: outstanding %0d req %0d, required <= %0d and <= %0d",
                 n_req - n_pop, n_req, BUF_DEPTH, (m_limit + 1) * (m_kern + 1));
      end
    end
    if (exp_valid_o && first_val < 0) first_val = cyc;
    if (exp_valid_o && exp_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got w=%0d k=%0d, required no word", exp_word_idx_o, exp_kernal_idx_o);
      end else begin
        e  = exp_q.pop_front();
        x1 = m_en ? e.d1 : '0;
        obs_lw = exp_last_word_o;
        obs_lk = exp_last_kernal_o;
        if ({exp_3x3_data_o, exp_1x1_data_o, exp_word_idx_o, exp_kernal_idx_o, exp_last_word_o, exp_last_kernal_o}
            !== {e.d3, x1, e.w, e.k, e.lw, e.lk}) begin
          errors++;
          $display("FAIL word: got d3=%h d1=%h w=%0d k=%0d lw=%b lk=%b, required d3=%h d1=%h w=%0d k=%0d lw=%b lk=%b",
                   exp_3x3_data_o, exp_1x1_data_o, exp_word_idx_o, exp_kernal_idx_o, exp_last_word_o,
                   exp_last_kernal_o, e.d3, x1, e.w, e.k, e.lw, e.lk);
        end
      end
      n_pop++;
    end
    if (pass_done_o) n_done++;
    if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
      p = pend_q.pop_front();
      squ_3x3_data_i = p.d3;
      squ_1x1_data_i = p.d1;
    end else begin
      squ_3x3_data_i = {$urandom, $urandom, $urandom};
      squ_1x1_data_i = ones_1x1 ? '1 : {$urandom, $urandom, $urandom};
    end
  end

  task automatic clear_model(input int l, input int k, input bit en);
    m_limit = l; m_kern = k; m_en = en;
    exp_q.delete(); pend_q.delete();
    n_req = 0; n_pop = 0; n_done = 0; first_req = -1; last_req = -1; first_val = -1;
  endtask

  task automatic do_start(input int l, input int k, input bit en);
    @(posedge clk_i); #1;
    cfg_limit = 9'(l); cfg_kern = 10'(k); exp_1x1_en_i = en; start_i = 1;
    @(posedge clk_i); #1;
    start_i = 0;
    clear_model(l, k, en);
  endtask

  // Asserts ready, drops it the cycle after the final request, waits for done
  task automatic run_pass(input bit rnd, output bit ok);
    int  tot = (m_limit + 1) * (m_kern + 1);
    int  base = n_done;
    bit  dropped = 0;
    ok = 0;
    squ_data_ready_i = 1;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(posedge clk_i); #1;
      if (rnd) exp_ready_i = 1'($urandom_range(0, 1));
      if (!dropped && n_req >= tot) begin
        squ_data_ready_i = 0;
        dropped = 1;
      end
      ok = dropped && n_done > base;
    end
    squ_data_ready_i = 0;
    exp_ready_i = 1;
  endtask

  task automatic wait_req(input int target, output bit ok);
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge clk_i);
      ok = n_req >= target;
    end
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n_i = 0;
    #1;
    checks++;
    if ({squ_data_req_o, exp_valid_o, pass_done_o, exp_last_word_o, exp_last_kernal_o} !== 5'b0 ||
        exp_3x3_data_o !== '0 || exp_1x1_data_o !== '0 || exp_word_idx_o !== '0 || exp_kernal_idx_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b valid=%b done=%b w=%0d k=%0d, required all 0",
               squ_data_req_o, exp_valid_o, pass_done_o, exp_word_idx_o, exp_kernal_idx_o);
    end
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1;
  endtask

  task automatic test_basic();
    bit ok;
    do_start(3, 1, 1);
    exp_ready_i = 1;
    run_pass(0, ok);
    repeat (5) @(posedge clk_i);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: pass_done not seen, required within budget"); end
    checks++;
    if (n_req != 8 || n_pop != 8) begin errors++; $display("FAIL basic_count: req %0d pop %0d, required 8 8", n_req, n_pop); end
    checks++;
    if (last_req - first_req != 7) begin errors++; $display("FAIL basic_consecutive: span %0d, required 7", last_req - first_req); end
    checks++;
    if (first_val - first_req != RD_LAT + 1) begin
      errors++; $display("FAIL basic_latency: got %0d, required %0d", first_val - first_req, RD_LAT + 1);
    end
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL basic_done: pulses %0d, required 1", n_done); end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_start(3, 1, 1);
    exp_ready_i = 0;
    squ_data_ready_i = 1;
    wait_req(1, ok);
    repeat (10) @(posedge clk_i);
    #1;
    checks++;
    if (n_req != BUF_DEPTH || n_pop != 0) begin
      errors++; $display("FAIL bp_stall: req %0d pop %0d, required %0d 0", n_req, n_pop, BUF_DEPTH);
    end
    exp_ready_i = 1;
    run_pass(0, ok);
    checks++;
    if (!ok || n_req != 8 || n_pop != 8 || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_resume: ok %0d req %0d pop %0d left %0d, required 1 8 8 0", ok, n_req, n_pop, exp_q.size());
    end
  endtask

  task automatic test_1x1_off();
    bit ok;
    ones_1x1 = 1;
    do_start(2, 1, 0);
    run_pass(1, ok);
    ones_1x1 = 0;
    checks++;
    if (!ok || n_pop != 6) begin errors++; $display("FAIL off1x1: ok %0d pop %0d, required 1 6", ok, n_pop); end
  endtask

  task automatic test_stale_ready();
    bit ok;
    do_start(1, 1, 1);
    exp_ready_i = 1;
    squ_data_ready_i = 1;
    wait_req(4, ok);
    repeat (6) @(posedge clk_i);
    #1;
    checks++;
    if (n_req != 4 || n_done != 0) begin
      errors++; $display("FAIL stale_hold: req %0d done %0d, required 4 0", n_req, n_done);
    end
    squ_data_ready_i = 0;
    for (int i = 0; i < 50 && n_done == 0; i++) @(posedge clk_i);
    #1;
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL stale_done: pulses %0d, required 1", n_done); end
    clear_model(1, 1, 1);
    run_pass(0, ok);
    checks++;
    if (!ok || n_req != 4 || n_pop != 4) begin
      errors++; $display("FAIL stale_second: ok %0d req %0d pop %0d, required 1 4 4", ok, n_req, n_pop);
    end
  endtask

  task automatic test_edge();
    bit ok;
    do_start(0, 0, 1);
    run_pass(0, ok);
    checks++;
    if (!ok || n_req != 1 || n_pop != 1 || {obs_lw, obs_lk} !== 2'b11) begin
      errors++; $display("FAIL edge: ok %0d req %0d pop %0d lw %b lk %b, required 1 1 1 1 1", ok, n_req, n_pop, obs_lw, obs_lk);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_start(3, 1, 1);
    exp_ready_i = 0;
    squ_data_ready_i = 1;
    wait_req(3, ok);
    @(posedge clk_i); #1;
    checks++;
    if (exp_valid_o !== 1'b1) begin errors++; $display("FAIL ar_fill: valid %b, required 1", exp_valid_o); end
    rst_n_i = 0;
    squ_data_ready_i = 0;
    #1;
    checks++;
    if ({exp_valid_o, squ_data_req_o} !== 2'b00 || exp_3x3_data_o !== '0 || exp_word_idx_o !== '0) begin
      errors++; $display("FAIL ar_outputs: valid %b req %b w %0d, required 0 0 0", exp_valid_o, squ_data_req_o, exp_word_idx_o);
    end
    clear_model(3, 1, 1);
    @(posedge clk_i); #1;
    rst_n_i = 1;
    exp_ready_i = 1;
    do_start(3, 1, 1);
    run_pass(0, ok);
    checks++;
    if (!ok || n_req != 8 || n_pop != 8) begin
      errors++; $display("FAIL ar_restart: ok %0d req %0d pop %0d, required 1 8 8", ok, n_req, n_pop);
    end
  endtask

  task automatic test_random();
    bit ok;
    int l, k, tot;
    for (int r = 0; r < 5; r++) begin
      l = $urandom_range(0, 4);
      k = $urandom_range(0, 2);
      tot = (l + 1) * (k + 1);
      do_start(l, k, 1'($urandom_range(0, 1)));
      run_pass(1, ok);
      checks++;
      if (!ok || n_req != tot || n_pop != tot || exp_q.size() != 0) begin
        errors++; $display("FAIL random_pass: ok %0d req %0d pop %0d left %0d, required 1 %0d %0d 0",
                           ok, n_req, n_pop, exp_q.size(), tot, tot);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_1x1_off();
    test_stale_ready();
    test_edge();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
